// File: rtl/dram_stream_reader.sv
// -----------------------------------------------------------------------------
// dram_stream_reader
//
// Sequential-read initiator for port 2 of the DRAM controller. A start pulse
// fetches word_count consecutive 32-bit words from base_addr into a small
// first-word-fall-through FIFO. The words leave on a valid/ready stream.
// At most one DRAM read is outstanding. A read is only issued when the FIFO has
// a free slot, so a returning word always fits.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   start      : 1-cycle pulse, begins a transfer (ignored while busy)
//   base_addr  : first word address, bit 23 expected 0
//   word_count : number of words to fetch (0 allowed)
//   abort      : cancel the current transfer
//   busy       : transfer in progress
//   done       : 1-cycle pulse, last word consumed or zero-length transfer
//   req2       : read request to the DRAM controller
//   addr2      : read address, stable while req2=1
//   odata2     : read data, valid while ack2=1
//   ack2       : 1-cycle completion pulse from the controller
//   s_data     : stream data (FIFO head)
//   s_valid    : FIFO non-empty
//   s_ready    : consumer accepts s_data when s_valid & s_ready
// -----------------------------------------------------------------------------
module dram_stream_reader #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             req2,
  output logic [23:0]      addr2,
  input  logic [31:0]      odata2,
  input  logic             ack2,
  output logic [31:0]      s_data,
  output logic             s_valid,
  input  logic             s_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DRAIN
  } state_e;

  state_e             state_q;
  logic [22:0]        addr_q;
  logic [CNT_W-1:0]   issue_left_q;
  logic [CNT_W-1:0]   deliver_left_q;
  logic               abort_pend_q;
  logic               busy_q;
  logic               done_q;
  logic               req2_q;

  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  logic fifo_full;
  logic push;
  logic pop;
  logic flush;
  logic last_pop;

  // Bit 23 of base_addr is architecturally zero; the address counter is 23 bits.
  logic unused_base_msb;
  assign unused_base_msb = base_addr[23];

  assign fifo_full = (count_q == DEPTH_C);
  assign s_valid   = (count_q != '0);
  assign pop       = s_valid && s_ready;
  assign last_pop  = pop && (deliver_left_q == CNT_W'(1));

  // Word acceptance and flush decisions, shared by the FSM and the FIFO.
  // An ack that completes an aborted read is thrown away together with the
  // FIFO contents.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    push  = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (ack2) begin
          if (abort_pend_q || abort) flush = 1'b1;
          else if (!fifo_full)       push  = 1'b1;
        end
      end
      S_GAP, S_DRAIN: begin
        if (abort) flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      abort_pend_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      req2_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) deliver_left_q <= deliver_left_q - CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          // abort has priority over a simultaneous start
          if (start && !abort) begin
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q         <= base_addr[22:0];
              issue_left_q   <= word_count;
              deliver_left_q <= word_count;
              busy_q         <= 1'b1;
              req2_q         <= 1'b1;
              state_q        <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // The controller has already latched addr2, so an abort here must
          // wait for the ack with req2 still high.
          if (abort) abort_pend_q <= 1'b1;
          if (ack2) begin
            req2_q <= 1'b0;
            if (abort_pend_q || abort) begin
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              addr_q       <= addr_q + 23'(1);
              issue_left_q <= issue_left_q - CNT_W'(1);
              state_q      <= S_GAP;
            end
          end
        end

        S_GAP: begin
          // At least one cycle with req2 low so the controller returns to idle.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (issue_left_q == '0) begin
            if (last_pop) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (!fifo_full) begin
            // A free slot now stays free: nothing else pushes until the ack.
            req2_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (last_pop) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // the reset pointers, and s_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= odata2;
  end

  assign s_data = s_valid ? mem_q[rd_ptr_q] : '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign req2   = req2_q;
  assign addr2  = {1'b0, addr_q};

  a_ack_only_in_req: assert property (@(posedge clk) disable iff (!reset_n)
    ack2 |-> (state_q == S_REQ))
    else $error("ack2 received outside REQ");

  a_ack_not_full: assert property (@(posedge clk) disable iff (!reset_n)
    (ack2 && state_q == S_REQ) |-> !fifo_full)
    else $error("ack2 received with FIFO full, word dropped");

endmodule

// File: tb/tb_dram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_dram_stream_reader
//
// Self-checking bench. A behavioural DRAM controller answers each request after
// a random (or forced) latency with a word derived from its address. The
// reference model is a pair of queues: addresses expected on addr2, and words
// expected on the stream, computed directly from base/count with modular
// arithmetic. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dram_stream_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [23:0] base_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        req2;
  logic [23:0] addr2;
  logic [31:0] odata2;
  logic        ack2;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  dram_stream_reader #(.FIFO_AW(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .req2       (req2),
    .addr2      (addr2),
    .odata2     (odata2),
    .ack2       (ack2),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int remaining   = -1;
  int acks_seen   = 0;
  int done_seen   = 0;
  int done_base   = 0;
  bit done_due    = 1'b0;
  int ready_mode  = 1;
  int lat_left    = -1;
  int lat_force   = -1;
  bit pulse_start = 1'b0;
  bit pulse_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [23:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: drive inputs for the coming edge, then score what that edge sees.
  task automatic step();
    @(negedge clk);
    start       = pulse_start;
    abort       = pulse_abort;
    pulse_start = 1'b0;
    pulse_abort = 1'b0;

    if (ack2) begin
      ack2 = 1'b0;
    end else if (req2) begin
      if (lat_left < 0) lat_left = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 8));
      if (lat_left == 0) begin
        ack2     = 1'b1;
        odata2   = word_of(addr2);
        lat_left = -1;
      end else begin
        lat_left--;
      end
    end

    case (ready_mode)
      0:       s_ready = 1'b0;
      1:       s_ready = 1'b1;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase

    if (done) done_seen++;
    if (done_due) begin
      check("done_timing", {31'd0, done}, 32'd1);
      done_due = 1'b0;
    end else if (done) begin
      check("done_unexpected", {31'd0, done}, 32'd0);
    end

    if (req2) begin
      if (exp_addr.size() == 0) begin
        check("req_unexpected", {31'd0, req2}, 32'd0);
      end else begin
        check("addr2", {8'd0, addr2}, {8'd0, exp_addr[0]});
        if (ack2) begin
          void'(exp_addr.pop_front());
          acks_seen++;
        end
      end
    end

    if (s_valid && s_ready) begin
      if (exp_data.size() == 0) begin
        check("pop_unexpected", {31'd0, s_valid}, 32'd0);
      end else begin
        check("s_data", s_data, exp_data.pop_front());
        remaining--;
        if (remaining == 0) done_due = 1'b1;
      end
    end
  endtask

  task automatic start_xfer(input logic [23:0] base, input int n, input int rmode);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      int unsigned a;
      a = (int'(base) + i) % (1 << 23);
      exp_addr.push_back(24'(a));
      exp_data.push_back(word_of(24'(a)));
    end
    remaining   = n;
    acks_seen   = 0;
    done_base   = done_seen;
    ready_mode  = rmode;
    base_addr   = base;
    word_count  = 16'(n);
    pulse_start = 1'b1;
    step();
    if (n == 0) done_due = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_seen == done_base && k < budget) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, {31'd0, done_seen != done_base}, 32'd1);
    repeat (3) step();
    check({tag, "_done_count"}, 32'(done_seen - done_base), 32'd1);
    check({tag, "_words_left"}, 32'(exp_data.size()), 32'd0);
    check({tag, "_reqs_left"}, 32'(exp_addr.size()), 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_s_valid"}, {31'd0, s_valid}, 32'd0);
  endtask

  task automatic run_xfer(input logic [23:0] base, input int n, input int rmode, input string tag);
    start_xfer(base, n, rmode);
    wait_done(tag, n * 20 + 100);
  endtask

  task automatic model_clear();
    exp_addr.delete();
    exp_data.delete();
    remaining = -1;
    done_due  = 1'b0;
  endtask

  initial begin
    int k;
    int d0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    s_ready = 1'b0; ack2 = 1'b0; odata2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_req2",    {31'd0, req2},    32'd0);
    check("rst_addr2",   {8'd0, addr2},    32'd0);
    check("rst_s_valid", {31'd0, s_valid}, 32'd0);
    check("rst_s_data",  s_data,           32'd0);
    reset_n = 1'b1;

    // Basic 4-word transfer
    run_xfer(24'h000100, 4, 1, "t1");

    // FIFO fills to 16 with a stalled consumer, then drains
    start_xfer(24'h001000, 20, 0);
    repeat (300) step();
    check("t2_acks",    32'(acks_seen),     32'd16);
    check("t2_req2_lo", {31'd0, req2},      32'd0);
    check("t2_s_valid", {31'd0, s_valid},   32'd1);
    check("t2_busy",    {31'd0, busy},      32'd1);
    ready_mode = 1;
    wait_done("t2", 400);

    // Address wrap at 2^23
    run_xfer(24'h7FFFFE, 4, 1, "t3");

    // Zero-length transfer
    run_xfer(24'h000050, 0, 1, "t4");

    // abort together with start in IDLE: nothing happens
    model_clear();
    d0          = done_seen;
    base_addr   = 24'h000600;
    word_count  = 16'd5;
    pulse_start = 1'b1;
    pulse_abort = 1'b1;
    repeat (5) step();
    check("t4b_busy", {31'd0, busy},          32'd0);
    check("t4b_req2", {31'd0, req2},          32'd0);
    check("t4b_done", 32'(done_seen - d0),    32'd0);

    // abort while a request is outstanding, ack delayed
    lat_force = 6;
    start_xfer(24'h000200, 8, 0);
    d0 = done_seen;
    k = 0;
    while (!req2 && k < 10) begin step(); k++; end
    check("t5_req_seen", {31'd0, req2}, 32'd1);
    pulse_abort = 1'b1;
    step();
    k = 0;
    while (!ack2 && k < 20) begin
      step();
      check("t5_req2_hold",  {31'd0, req2}, 32'd1);
      check("t5_addr2_hold", {8'd0, addr2}, 32'h0000_0200);
      k++;
    end
    check("t5_ack_seen", {31'd0, ack2}, 32'd1);
    model_clear();
    step();
    check("t5_s_valid", {31'd0, s_valid}, 32'd0);
    check("t5_busy",    {31'd0, busy},    32'd0);
    check("t5_req2",    {31'd0, req2},    32'd0);
    repeat (5) step();
    check("t5_no_done", 32'(done_seen - d0), 32'd0);
    lat_force = -1;
    run_xfer(24'h000300, 5, 2, "t5_restart");

    // abort after all words are fetched (GAP/DRAIN)
    start_xfer(24'h000700, 3, 0);
    d0 = done_seen;
    k = 0;
    while (exp_addr.size() != 0 && k < 100) begin step(); k++; end
    check("t5b_fetched", 32'(exp_addr.size()), 32'd0);
    step();
    pulse_abort = 1'b1;
    step();
    model_clear();
    step();
    check("t5b_s_valid", {31'd0, s_valid}, 32'd0);
    check("t5b_busy",    {31'd0, busy},    32'd0);
    repeat (3) step();
    check("t5b_no_done", 32'(done_seen - d0), 32'd0);

    // asynchronous reset while a request is outstanding
    start_xfer(24'h000400, 8, 0);
    k = 0;
    while ((acks_seen < 2 || !req2) && k < 200) begin step(); k++; end
    check("t6_in_req", {31'd0, req2}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy",    {31'd0, busy},    32'd0);
    check("t6_done",    {31'd0, done},    32'd0);
    check("t6_req2",    {31'd0, req2},    32'd0);
    check("t6_addr2",   {8'd0, addr2},    32'd0);
    check("t6_s_valid", {31'd0, s_valid}, 32'd0);
    check("t6_s_data",  s_data,           32'd0);
    ack2     = 1'b0;
    lat_left = -1;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    run_xfer(24'h000100, 4, 1, "t6_after");

    // randomized transfers, some near the address wrap
    for (int r = 0; r < 6; r++) begin
      logic [23:0] b;
      int n;
      if (r % 2 == 0) b = 24'($urandom_range(0, 32'h7F_FFFF));
      else            b = 24'h7FFFF0 + 24'($urandom_range(0, 15));
      n = int'($urandom_range(1, 40));
      run_xfer(b, n, 2, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
